simon_decrypt_core: RTL and testbench
=====================================

SIMON_DECRYPT_CORE -- requirements
Module: simon_decrypt_core

Interface
Parameters:
REQ-001 SHALL have parameter WORD_SIZE, default 64: bit width of each half-block (x, y) and of the round key.
REQ-002 SHALL have parameter ROUNDS, default 68: number of decryption rounds per block; legal range 1..255.
Ports:
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port start  input  1  request to load a ciphertext block; sampled only when the core is not busy.
REQ-006 SHALL have port ct_x  input  WORD_SIZE  ciphertext upper word, sampled with start.
REQ-007 SHALL have port ct_y  input  WORD_SIZE  ciphertext lower word, sampled with start.
REQ-008 SHALL have port key_idx  output  8  index of the round key the core needs this cycle.
REQ-009 SHALL have port round_key  input  WORD_SIZE  round key k[key_idx], supplied combinationally in the same cycle.
REQ-010 SHALL have port busy  output  1  high while rounds are in progress.
REQ-011 SHALL have port done  output  1  one-cycle pulse marking valid plaintext.
REQ-012 SHALL have port pt_x  output  WORD_SIZE  plaintext upper word.
REQ-013 SHALL have port pt_y  output  WORD_SIZE  plaintext lower word.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE.
- IDLE or DONE with start=1 -> RUN.
- RUN after the final round -> DONE.
- DONE with start=0 -> IDLE.
REQ-015 SHALL, on an accepted start, load x<=ct_x, y<=ct_y and round counter<=ROUNDS-1.
REQ-016 SHALL drive key_idx = round counter in RUN, and 0 in IDLE and DONE.
REQ-017 SHALL apply one inverse round per RUN cycle:
- x_next = y
- y_next = x ^ f(y) ^ round_key
- f(v) = (ROL1(v) & ROL8(v)) ^ ROL2(v)
- ROLn is a circular left rotate modulo WORD_SIZE.
REQ-018 SHALL consume keys in descending order, ROUNDS-1 down to 0, one per cycle; the counter decrements by 1 and never wraps below 0.
REQ-019 SHALL, in the RUN cycle with counter=0, apply the last round and transition to DONE.
REQ-020 SHALL have fixed latency: start accepted at edge N -> done=1 during the cycle after edge N+ROUNDS.
REQ-021 SHALL assert busy exactly in RUN, and assert done exactly in DONE (one cycle).
REQ-022 SHALL drive pt_x/pt_y from the x/y registers; they are valid while done=1 and are held stable until the next accepted start.
REQ-023 SHALL ignore start while busy=1: no reload and no effect on the rounds in progress.
REQ-024 SHALL accept start in DONE with no bubble, so back-to-back blocks have a throughput of one block per ROUNDS+1 cycles.
REQ-025 SHALL, when ROUNDS=1, perform one RUN cycle, then DONE.

Reset
REQ-026 SHALL, with rst_n=0 at a clock edge, go to IDLE and set x, y, the counter, pt_x and pt_y to 0, with busy=0, done=0, key_idx=0.
REQ-027 SHALL let reset take priority over start and abort a block mid-RUN: no done is produced, and the next start after release behaves as the first.
REQ-028 SHALL ignore start sampled in the same cycle as rst_n=0.

Verification
REQ-029 SHALL cover single round (WORD_SIZE=16, ROUNDS=1): ct_x=0x1234, ct_y=0x0001, round_key=0x00FF -> pt_x=0x0001, pt_y=0x12CF, done 2 cycles after the start edge.
REQ-030 SHALL cover the full block (defaults): SIMON128/128 key 0x0f0e0d0c0b0a0908_0706050403020100, bench model supplies k[key_idx]; ct=0x65aa832af84e0bbc_49681b1e1e54fe3f -> pt=0x6c6c657661727420_6373656420737265 after 68 busy cycles.
REQ-031 SHALL cover key order (defaults): key_idx reads 67, 66, ..., 0 on consecutive busy cycles with no repeats; key_idx=0 when idle.
REQ-032 SHALL cover start while busy: pulse start with a different ct at round 10 -> the result equals the first block and done pulses once.
REQ-033 SHALL cover back-to-back blocks: start held high across DONE -> the second block begins the cycle after done, and both results are correct.
REQ-034 SHALL cover reset mid-run: rst_n=0 at round 30 -> next cycle busy=0, done=0, pt=0; a fresh block afterwards decrypts correctly.

Source files
------------

// File: rtl/simon_decrypt_core.sv
// Iterative SIMON block decryptor: one inverse Feistel round per clock, with the
// round keys fetched from outside in descending index order through key_idx/round_key.
module simon_decrypt_core #(
  parameter int unsigned WORD_SIZE = 64,
  parameter int unsigned ROUNDS    = 68
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WORD_SIZE-1:0] ct_x,
  input  logic [WORD_SIZE-1:0] ct_y,
  output logic [7:0]           key_idx,
  input  logic [WORD_SIZE-1:0] round_key,
  output logic                 busy,
  output logic                 done,
  output logic [WORD_SIZE-1:0] pt_x,
  output logic [WORD_SIZE-1:0] pt_y
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [7:0] LAST_RND = 8'(ROUNDS - 1);

  state_e               state_q, state_d;
  logic [WORD_SIZE-1:0] x_q, x_d;
  logic [WORD_SIZE-1:0] y_q, y_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [WORD_SIZE-1:0] f_y;

  function automatic logic [WORD_SIZE-1:0] rotl(input logic [WORD_SIZE-1:0] v,
                                                input int unsigned n);
    int unsigned s;
    s = n % WORD_SIZE;
    return (v << s) | (v >> ((WORD_SIZE - s) % WORD_SIZE));
  endfunction

  // SIMON round function on the current y half.
  assign f_y = (rotl(y_q, 1) & rotl(y_q, 8)) ^ rotl(y_q, 2);

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          x_d     = ct_x;
          y_d     = ct_y;
          cnt_d   = LAST_RND;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        x_d = y_q;
        y_d = x_q ^ f_y ^ round_key;
        if (cnt_q == 8'd0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values; reset here is synchronous and wins over start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign key_idx = busy ? cnt_q : 8'd0;
  assign pt_x    = x_q;
  assign pt_y    = y_q;

endmodule

// File: tb/tb_simon_decrypt_core.sv
// Bench for simon_decrypt_core: a SIMON128/128 instance with a key-schedule model
// feeding round keys, plus a 16-bit single-round instance; results checked by scoreboards.
module tb_simon_decrypt_core;

  typedef struct packed {
    logic [63:0] x;
    logic [63:0] y;
  } blk_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [63:0] ct_x, ct_y;
  logic [7:0]  key_idx;
  logic [63:0] round_key;
  logic        busy, done;
  logic [63:0] pt_x, pt_y;

  logic        start1;
  logic [15:0] ct_x1, ct_y1;
  logic [7:0]  key_idx1;
  logic [15:0] round_key1;
  logic        busy1, done1;
  logic [15:0] pt_x1, pt_y1;

  logic [63:0] rk [0:255];
  blk_t        exp_q[$];
  logic [31:0] exp1_q[$];
  int          total = 0;
  int          bad = 0;
  int          done_pulses = 0;

  always #5 clk = ~clk;

  simon_decrypt_core dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ct_x(ct_x), .ct_y(ct_y),
    .key_idx(key_idx), .round_key(round_key), .busy(busy), .done(done),
    .pt_x(pt_x), .pt_y(pt_y)
  );

  simon_decrypt_core #(.WORD_SIZE(16), .ROUNDS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .ct_x(ct_x1), .ct_y(ct_y1),
    .key_idx(key_idx1), .round_key(round_key1), .busy(busy1), .done(done1),
    .pt_x(pt_x1), .pt_y(pt_y1)
  );

  assign round_key  = rk[key_idx];
  assign round_key1 = 16'h00FF;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rol(input logic [63:0] v, input int n);
    return (v << n) | (v >> (64 - n));
  endfunction

  function automatic logic [63:0] ror(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  // Reference inverse cipher: keys applied 67 down to 0.
  function automatic blk_t model(input logic [63:0] cx, input logic [63:0] cy);
    logic [63:0] x, y, t;
    x = cx;
    y = cy;
    for (int r = 67; r >= 0; r--) begin
      t = x ^ ((rol(y, 1) & rol(y, 8)) ^ rol(y, 2)) ^ rk[r];
      x = y;
      y = t;
    end
    return '{x: x, y: y};
  endfunction

  // Scoreboard monitors: pop one expected block per done pulse.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_pulses++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_done: got pt %h_%h want no result", pt_x, pt_y);
      end else begin
        blk_t e;
        e = exp_q.pop_front();
        check("pt_x", pt_x, e.x);
        check("pt_y", pt_y, e.y);
      end
    end
  end

  always @(negedge clk) begin
    if (done1 === 1'b1) begin
      if (exp1_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_done1: got pt %h_%h want no result", pt_x1, pt_y1);
      end else begin
        logic [31:0] e1;
        e1 = exp1_q.pop_front();
        check("pt_x1", 64'(pt_x1), 64'(e1[31:16]));
        check("pt_y1", 64'(pt_y1), 64'(e1[15:0]));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1);
  end

  localparam logic [63:0] KCT_X = 64'h49681b1e1e54fe3f;
  localparam logic [63:0] KCT_Y = 64'h65aa832af84e0bbc;
  localparam logic [63:0] KPT_X = 64'h6373656420737265;
  localparam logic [63:0] KPT_Y = 64'h6c6c657661727420;

  initial begin
    logic [63:0] z2;
    blk_t        known, e2, e3;
    int          pulses_before;

    // SIMON128/128 key schedule, key 0f0e0d0c0b0a0908_0706050403020100.
    z2 = 64'h7369f885192c0ef5;
    for (int i = 0; i < 256; i++) rk[i] = '0;
    rk[0] = 64'h0706050403020100;
    rk[1] = 64'h0f0e0d0c0b0a0908;
    for (int i = 0; i < 66; i++)
      rk[i+2] = ~64'h3 ^ 64'(z2[i % 62]) ^ rk[i] ^ ror(rk[i+1], 3) ^ ror(rk[i+1], 4);
    known = '{x: KPT_X, y: KPT_Y};
    e2 = model(64'h0123456789abcdef, 64'hfedcba9876543210);
    e3 = model(64'hdeadbeefcafef00d, 64'h0011223344556677);

    // Reset with start asserted: start must be ignored.
    rst_n = 1'b0; start = 1'b1; start1 = 1'b1;
    ct_x = KCT_X; ct_y = KCT_Y; ct_x1 = 16'h1234; ct_y1 = 16'h0001;
    tick(); tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_key_idx", 64'(key_idx), 64'd0);
    check("rst_pt_x", pt_x, 64'd0);
    check("rst_pt_y", pt_y, 64'd0);
    check("rst_busy1", 64'(busy1), 64'd0);
    start = 1'b0; start1 = 1'b0;
    rst_n = 1'b1;
    tick();
    check("idle_busy", 64'(busy), 64'd0);

    // Single-round core: 0x1234/0x0001 with key 0x00FF.
    start1 = 1'b1;
    exp1_q.push_back({16'h0001, 16'h12CF});
    tick();
    start1 = 1'b0;
    check("r1_busy", 64'(busy1), 64'd1);
    check("r1_key_idx", 64'(key_idx1), 64'd0);
    check("r1_done_early", 64'(done1), 64'd0);
    tick();
    check("r1_done", 64'(done1), 64'd1);
    check("r1_busy_after", 64'(busy1), 64'd0);
    tick();
    check("r1_done_once", 64'(done1), 64'd0);

    // Full known-answer block with key order check.
    start = 1'b1; ct_x = KCT_X; ct_y = KCT_Y;
    exp_q.push_back(known);
    tick();
    start = 1'b0;
    for (int r = 0; r < 68; r++) begin
      check("kat_busy", 64'(busy), 64'd1);
      check("kat_key_idx", 64'(key_idx), 64'(67 - r));
      tick();
    end
    check("kat_done", 64'(done), 64'd1);
    check("kat_busy_done", 64'(busy), 64'd0);
    check("kat_key_idx_done", 64'(key_idx), 64'd0);
    tick();
    check("kat_done_pulse", 64'(done), 64'd0);
    check("kat_key_idx_idle", 64'(key_idx), 64'd0);
    check("kat_pt_hold_x", pt_x, KPT_X);

    // Start pulsed with a different block at round 10 must be ignored.
    pulses_before = done_pulses;
    start = 1'b1; ct_x = KCT_X; ct_y = KCT_Y;
    exp_q.push_back(known);
    tick();
    start = 1'b0;
    for (int r = 0; r < 10; r++) tick();
    start = 1'b1; ct_x = 64'h1111111111111111; ct_y = 64'h2222222222222222;
    tick();
    start = 1'b0;
    check("busy_ign_key_idx", 64'(key_idx), 64'd56);
    for (int r = 0; r < 57; r++) tick();
    check("busy_ign_done", 64'(done), 64'd1);
    tick();
    check("busy_ign_pulses", 64'(done_pulses - pulses_before), 64'd1);

    // Back-to-back: start held high through DONE.
    start = 1'b1; ct_x = KCT_X; ct_y = KCT_Y;
    exp_q.push_back(known);
    tick();
    ct_x = 64'h0123456789abcdef; ct_y = 64'hfedcba9876543210;
    exp_q.push_back(e2);
    for (int r = 0; r < 68; r++) tick();
    check("b2b_done1", 64'(done), 64'd1);
    tick();
    start = 1'b0;
    check("b2b_restart_busy", 64'(busy), 64'd1);
    check("b2b_restart_key", 64'(key_idx), 64'd67);
    check("b2b_restart_done", 64'(done), 64'd0);
    for (int r = 0; r < 68; r++) tick();
    check("b2b_done2", 64'(done), 64'd1);
    tick();

    // Reset at round 30 aborts the block; a fresh block follows.
    start = 1'b1; ct_x = KCT_X; ct_y = KCT_Y;
    tick();
    start = 1'b0;
    for (int r = 0; r < 30; r++) tick();
    check("mid_key_idx", 64'(key_idx), 64'd37);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    check("mid_rst_pt_x", pt_x, 64'd0);
    check("mid_rst_pt_y", pt_y, 64'd0);
    check("mid_rst_key_idx", 64'(key_idx), 64'd0);
    start = 1'b1; ct_x = 64'hdeadbeefcafef00d; ct_y = 64'h0011223344556677;
    exp_q.push_back(e3);
    tick();
    start = 1'b0;
    check("fresh_key_idx", 64'(key_idx), 64'd67);
    for (int r = 0; r < 68; r++) tick();
    check("fresh_done", 64'(done), 64'd1);
    tick(); tick(); tick();

    check("sb_empty", 64'(exp_q.size()), 64'd0);
    check("sb1_empty", 64'(exp1_q.size()), 64'd0);
    check("done_pulses", 64'(done_pulses), 64'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
